// File: rtl/bcd2bin.sv
`default_nettype none
// ============================================================================
//  Module   : bcd2bin
//  Purpose  : Sequential BCD-to-binary converter (reverse double-dabble).
//             A packed DIGITS-digit BCD word is captured on an en strobe and
//             converted with one shift or one adjust step per clock. rdy
//             pulses for one cycle when the result is ready.
//  Ports    : clk        - clock, all state updates on posedge
//             rst_n      - asynchronous active-low reset
//             en         - start strobe, sampled only while busy==0
//             bcd_d_in   - packed BCD operand, digit 0 = bits [3:0]
//             bin_d_out  - binary result, holds until the next completion
//             rdy        - one-cycle completion pulse
//             busy       - conversion in progress
//             err        - last completion saw a digit > 9
//  Revision : 1.0 - initial release
// ============================================================================
module bcd2bin #(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   bcd_d_in,
    output logic [BIN_W-1:0]      bin_d_out,
    output logic                  rdy,
    output logic                  busy,
    output logic                  err
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ADJUST = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [c_BCD_W-1:0]   r_bcd,   w_bcd_nxt;
    logic [BIN_W-1:0]     r_bin,   w_bin_nxt;
    logic [c_CNT_W-1:0]   r_cnt,   w_cnt_nxt;
    logic                 r_flag,  w_flag_nxt;
    logic [BIN_W-1:0]     w_out_nxt;
    logic                 w_rdy_nxt, w_busy_nxt, w_err_nxt;

    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [c_BCD_W-1:0]   w_bcd_sh;
    logic [BIN_W-1:0]     w_bin_sh;
    logic [DIGITS-1:0]    w_digit_bad;

    // Per-digit helpers: the -3 correction undoes the halving of a carried
    // ten (10/2 = 5 must read as 5, but a shifted-in 1 adds 8 to the digit
    // below), and the validity check on the incoming operand.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        assign w_bcd_adj[4*g +: 4]  = (r_bcd[4*g +: 4] >= 4'd8) ? (r_bcd[4*g +: 4] - 4'd3)
                                                                : r_bcd[4*g +: 4];
        assign w_digit_bad[g]       = (bcd_d_in[4*g +: 4] > 4'd9);
    end

    // Whole work register shifts right; the BCD LSB drops into the bin MSB.
    assign {w_bcd_sh, w_bin_sh} = {r_bcd, r_bin} >> 1;

    always_comb begin
        w_state_nxt = r_state;
        w_bcd_nxt   = r_bcd;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = r_cnt;
        w_flag_nxt  = r_flag;
        w_out_nxt   = bin_d_out;
        w_rdy_nxt   = 1'b0;
        w_busy_nxt  = busy;
        w_err_nxt   = err;

        case (r_state)
            IDLE: begin
                if (en) begin
                    w_busy_nxt = 1'b1;
                    w_bcd_nxt  = bcd_d_in;
                    w_bin_nxt  = '0;
                    if (|w_digit_bad) begin
                        w_state_nxt = DONE;
                        w_flag_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = SHIFT;
                        w_flag_nxt  = 1'b0;
                    end
                end
            end
            SHIFT: begin
                w_bcd_nxt = w_bcd_sh;
                w_bin_nxt = w_bin_sh;
                if (r_cnt == c_CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = ADJUST;
                end
            end
            ADJUST: begin
                w_bcd_nxt   = w_bcd_adj;
                w_state_nxt = SHIFT;
            end
            DONE: begin
                w_rdy_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_err_nxt   = r_flag;
                w_out_nxt   = r_flag ? '0 : r_bin;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bcd     <= '0;
            r_bin     <= '0;
            r_cnt     <= '0;
            r_flag    <= 1'b0;
            bin_d_out <= '0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bcd     <= w_bcd_nxt;
            r_bin     <= w_bin_nxt;
            r_cnt     <= w_cnt_nxt;
            r_flag    <= w_flag_nxt;
            bin_d_out <= w_out_nxt;
            rdy       <= w_rdy_nxt;
            busy      <= w_busy_nxt;
            err       <= w_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd2bin.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd2bin
//  Purpose  : Self-checking bench for bcd2bin; directed cases plus random
//             operands compared against a decimal-arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd2bin;

    localparam int DIGITS = 4;
    localparam int BIN_W  = 14;

    logic                 clk;
    logic                 rst_n;
    logic                 en;
    logic [4*DIGITS-1:0]  bcd_d_in;
    logic [BIN_W-1:0]     bin_d_out;
    logic                 rdy;
    logic                 busy;
    logic                 err;

    int n_checks;
    int n_fail;

    bcd2bin #(.DIGITS(DIGITS), .BIN_W(BIN_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .bcd_d_in  (bcd_d_in),
        .bin_d_out (bin_d_out),
        .rdy       (rdy),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, obs, obs, exp_v, exp_v, $time);
        end
    endtask

    // Reference: decimal value from digit weights, invalid if any digit > 9.
    function automatic void model(input logic [4*DIGITS-1:0] v, output int val, output bit bad);
        int w;
        int d;
        val = 0;
        bad = 1'b0;
        w   = 1;
        for (int i = 0; i < DIGITS; i++) begin
            d = int'(v[4*i +: 4]);
            if (d > 9) bad = 1'b1;
            val += d * w;
            w   *= 10;
        end
        if (bad) val = 0;
    endfunction

    // One conversion. glitch_at >= 0 pulses en (with 9999) that many edges
    // after the accepting edge, which must be ignored.
    task automatic run_conv(input logic [4*DIGITS-1:0] v, input int glitch_at);
        int  exp_val;
        bit  exp_bad;
        int  n;
        bit  got;
        model(v, exp_val, exp_bad);
        @(negedge clk);
        en       = 1'b1;
        bcd_d_in = v;
        @(posedge clk);
        #1;
        en = 1'b0;
        check("busy_after_accept", busy, 1);
        n   = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            if (n == glitch_at) begin
                en       = 1'b1;
                bcd_d_in = 16'h9999;
            end
            @(posedge clk);
            n++;
            #1;
            en = 1'b0;
            if (rdy) got = 1'b1;
        end
        check("rdy_seen", got, 1);
        check("latency", n, exp_bad ? 1 : 2*BIN_W);
        check("bin_d_out", bin_d_out, exp_val);
        check("err", err, exp_bad);
        check("busy_at_rdy", busy, 0);
        @(posedge clk);
        #1;
        check("rdy_one_cycle", rdy, 0);
        check("bin_hold", bin_d_out, exp_val);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        int  rdy_cnt;
        int  t_first;
        logic [4*DIGITS-1:0] v;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        en       = 1'b0;
        bcd_d_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_bin", bin_d_out, 0);
        check("reset_rdy", rdy, 0);
        check("reset_busy", busy, 0);
        check("reset_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed operands, including an invalid digit and an ignored en.
        run_conv(16'h9999, -1);
        run_conv(16'h1234, -1);
        run_conv(16'h0000, -1);
        run_conv(16'h12A4, -1);
        run_conv(16'h0042, 10);

        // Abort mid-conversion by reset.
        @(negedge clk);
        en       = 1'b1;
        bcd_d_in = 16'h5678;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_bin", bin_d_out, 0);
        check("abort_busy", busy, 0);
        check("abort_rdy", rdy, 0);
        @(negedge clk);
        rst_n   = 1'b1;
        rdy_cnt = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (rdy) rdy_cnt++;
        end
        check("abort_no_rdy", rdy_cnt, 0);

        // en held high: back-to-back conversions.
        @(negedge clk);
        en       = 1'b1;
        bcd_d_in = 16'h0001;
        n        = 0;
        t_first  = -1;
        rdy_cnt  = 0;
        while (rdy_cnt < 2 && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (rdy) begin
                rdy_cnt++;
                if (rdy_cnt == 1) begin
                    t_first  = n;
                    check("b2b_first", bin_d_out, 1);
                    bcd_d_in = 16'h0100;
                end else begin
                    check("b2b_gap", n - t_first, 2*BIN_W + 1);
                    check("b2b_second", bin_d_out, 100);
                    en = 1'b0;
                end
            end
        end
        en = 1'b0;
        check("b2b_count", rdy_cnt, 2);
        repeat (2 * BIN_W + 4) @(posedge clk);

        // Random operands, mostly valid.
        for (int k = 0; k < 24; k++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if ($urandom_range(0, 9) == 0)
                    v[4*d +: 4] = 4'($urandom_range(10, 15));
                else
                    v[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            run_conv(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
